// File: rtl/mem_arb_pkg.sv
// Shared IDs, tag format and default sizes for the block-RAM port A arbiter.
package mem_arb_pkg;

   localparam int NUM_REQ        = 3;
   localparam int STARVE_W       = 8;
   localparam int ADDR_W_DEF     = 16;
   localparam int DATA_W_DEF     = 16;
   localparam int RD_LAT_DEF     = 1;
   localparam int STARVE_MAX_DEF = 8;

   typedef enum logic [1:0] {
      ID_LS = 2'd0,
      ID_F  = 2'd1,
      ID_IO = 2'd2
   } req_id_e;

   typedef struct packed {
      logic    valid;
      req_id_e id;
   } tag_t;

endpackage

// File: rtl/mem_arb_prio_sel.sv
// Combinational winner picker: ls > f > io, unless io_boost lifts a waiting io to the top.
module mem_arb_prio_sel
   import mem_arb_pkg::*;
(
   input  logic               ls_req,
   input  logic               f_req,
   input  logic               io_req,
   input  logic               io_boost,
   output logic [NUM_REQ-1:0] gnt_vec
);

   always_comb begin
      gnt_vec = '0;
      if (io_boost && io_req) gnt_vec[ID_IO] = 1'b1;
      else if (ls_req)        gnt_vec[ID_LS] = 1'b1;
      else if (f_req)         gnt_vec[ID_F]  = 1'b1;
      else if (io_req)        gnt_vec[ID_IO] = 1'b1;
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Three-way arbiter for RAM port A with registered command and in-order read-return tags.
// Optional MEM_ARB_STATS_EN adds saturating grant/conflict counters with a synchronous clear.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int RD_LAT     = RD_LAT_DEF,
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              f_req,
   input  logic [ADDR_W-1:0] f_addr,
   output logic              f_gnt,
   output logic              f_rvalid,
   input  logic              ls_req,
   input  logic              ls_we,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [DATA_W-1:0] ls_wdata,
   output logic              ls_gnt,
   output logic              ls_rvalid,
   input  logic              io_req,
   input  logic              io_we,
   input  logic [ADDR_W-1:0] io_addr,
   input  logic [DATA_W-1:0] io_wdata,
   output logic              io_gnt,
   output logic              io_rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
`ifdef MEM_ARB_STATS_EN
   ,
   input  logic              stats_clr,
   output logic [15:0]       st_f_cnt,
   output logic [15:0]       st_ls_cnt,
   output logic [15:0]       st_io_cnt,
   output logic [15:0]       st_conf_cnt
`endif
);

   logic [NUM_REQ-1:0]  gnt_sel;
   logic [NUM_REQ-1:0]  gnt_vec;
   logic [STARVE_W-1:0] starve_cnt;
   logic                io_boost;

   logic                vld_p0;
   logic                cmd_we_p0;
   logic [ADDR_W-1:0]   cmd_addr_p0;
   logic [DATA_W-1:0]   cmd_wdata_p0;
   req_id_e             cmd_id_p0;

   tag_t                tag_p1 [0:RD_LAT];
   tag_t                tag_out;

   assign io_boost = (starve_cnt >= STARVE_W'(STARVE_MAX - 1));

   mem_arb_prio_sel u_prio_sel (
      .ls_req   (ls_req),
      .f_req    (f_req),
      .io_req   (io_req),
      .io_boost (io_boost),
      .gnt_vec  (gnt_sel)
   );

   // Grants are suppressed while reset is held so every output reads 0.
   assign gnt_vec = reset ? '0 : gnt_sel;
   assign ls_gnt  = gnt_vec[ID_LS];
   assign f_gnt   = gnt_vec[ID_F];
   assign io_gnt  = gnt_vec[ID_IO];
   assign vld_p0  = |gnt_vec;

   // Stage p0: winner's command selection
   always_comb begin
      cmd_we_p0    = 1'b0;
      cmd_addr_p0  = '0;
      cmd_wdata_p0 = '0;
      cmd_id_p0    = ID_LS;
      if (gnt_vec[ID_LS]) begin
         cmd_we_p0    = ls_we;
         cmd_addr_p0  = ls_addr;
         cmd_wdata_p0 = ls_we ? ls_wdata : '0;
         cmd_id_p0    = ID_LS;
      end else if (gnt_vec[ID_F]) begin
         cmd_addr_p0  = f_addr;
         cmd_id_p0    = ID_F;
      end else if (gnt_vec[ID_IO]) begin
         cmd_we_p0    = io_we;
         cmd_addr_p0  = io_addr;
         cmd_wdata_p0 = io_we ? io_wdata : '0;
         cmd_id_p0    = ID_IO;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                 starve_cnt <= '0;
      else if (!io_req || io_gnt) starve_cnt <= '0;
      else                       starve_cnt <= starve_cnt + STARVE_W'(1);
   end

   // Stage p1: RAM command register and read tag shift register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ram_en    <= 1'b0;
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         for (int i = 0; i <= RD_LAT; i++) tag_p1[i] <= '0;
      end else begin
         ram_en    <= vld_p0;
         ram_we    <= cmd_we_p0;
         ram_addr  <= cmd_addr_p0;
         ram_wdata <= cmd_wdata_p0;
         tag_p1[0] <= '{valid: vld_p0 && !cmd_we_p0, id: cmd_id_p0};
         for (int i = 1; i <= RD_LAT; i++) tag_p1[i] <= tag_p1[i-1];
      end
   end

   // Tag at depth RD_LAT lines up with the RAM's read data.
   assign tag_out   = tag_p1[RD_LAT];
   assign ls_rvalid = tag_out.valid && (tag_out.id == ID_LS);
   assign f_rvalid  = tag_out.valid && (tag_out.id == ID_F);
   assign io_rvalid = tag_out.valid && (tag_out.id == ID_IO);
   assign rdata     = tag_out.valid ? ram_rdata : '0;

`ifdef MEM_ARB_STATS_EN
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   logic conflict;
   assign conflict = (ls_req & f_req) | (ls_req & io_req) | (f_req & io_req);

   always_ff @(posedge clk or posedge reset) begin
      if (reset || stats_clr) begin
         st_f_cnt    <= '0;
         st_ls_cnt   <= '0;
         st_io_cnt   <= '0;
         st_conf_cnt <= '0;
      end else begin
         if (f_gnt)    st_f_cnt    <= sat_inc(st_f_cnt);
         if (ls_gnt)   st_ls_cnt   <= sat_inc(st_ls_cnt);
         if (io_gnt)   st_io_cnt   <= sat_inc(st_io_cnt);
         if (conflict) st_conf_cnt <= sat_inc(st_conf_cnt);
      end
   end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_mem_port_arbiter;

   localparam int LS = 0, F = 1, IO = 2;
   localparam int SMAX = 8;
   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        f_req, ls_req, ls_we, io_req, io_we;
   logic [15:0] f_addr, ls_addr, ls_wdata, io_addr, io_wdata;
   logic        f_gnt, f_rvalid, ls_gnt, ls_rvalid, io_gnt, io_rvalid;
   logic [15:0] rdata;
   logic        ram_en, ram_we;
   logic [15:0] ram_addr, ram_wdata, ram_rdata;
`ifdef MEM_ARB_STATS_EN
   logic        stats_clr;
   logic [15:0] st_f_cnt, st_ls_cnt, st_io_cnt, st_conf_cnt;
`endif

   mem_port_arbiter dut (
      .clk(clk), .reset(reset),
      .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid),
      .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
      .io_gnt(io_gnt), .io_rvalid(io_rvalid),
      .rdata(rdata), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
`ifdef MEM_ARB_STATS_EN
      , .stats_clr(stats_clr), .st_f_cnt(st_f_cnt), .st_ls_cnt(st_ls_cnt),
      .st_io_cnt(st_io_cnt), .st_conf_cnt(st_conf_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct { int due; logic we; logic [15:0] addr; logic [15:0] wdata; } cmd_t;
   typedef struct { int due; int id; logic [15:0] data; } rd_t;

   cmd_t        cmd_q[$];
   rd_t         rd_q[$];
   int          cyc = 0;
   int          n_chk = 0, n_fail = 0;
   bit          act [3];
   logic        r_we [3];
   logic [15:0] r_addr [3];
   logic [15:0] r_wd [3];
   logic [15:0] model_mem [256];
   int          m_starve = 0;
   int          m_cnt [3];
   int          m_conf = 0;
   int          dut_gnt_cyc [3];
   logic [2:0]  last_dut_gnt;

   // Simple RD_LAT=1 RAM; unwritten words return a fixed pattern.
   logic [15:0] ram_mem [256];
   bit   [255:0] written = '0;

   function automatic logic [15:0] init_val(input int a);
      return (a == 16) ? 16'hBEEF : 16'((a * 16'h0301) ^ 16'hA5C3);
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) begin
            ram_mem[ram_addr[7:0]] <= ram_wdata;
            written[ram_addr[7:0]] <= 1'b1;
         end else begin
            ram_rdata <= written[ram_addr[7:0]] ? ram_mem[ram_addr[7:0]] : init_val(int'(ram_addr[7:0]));
         end
      end
   end

   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, got, exp);
      end
   endtask

   function automatic int pick(input bit [2:0] rq, input int starve);
      int order [3] = '{LS, F, IO};
      if (rq[IO] && starve >= SMAX - 1) return IO;
      foreach (order[k]) if (rq[order[k]]) return order[k];
      return -1;
   endfunction

   // Monitor: compares RAM port and read returns against the queued expectations.
   always @(negedge clk) begin
      cmd_t       ec;
      rd_t        er;
      logic       exp_en;
      logic [2:0] exp_rv;
      logic [15:0] exp_rd;
      if (reset) begin
         check("reset_outputs",
               {f_gnt, ls_gnt, io_gnt, f_rvalid, ls_rvalid, io_rvalid, rdata, ram_en, ram_we, ram_addr, ram_wdata},
               64'h0);
      end else begin
         exp_en = 1'b0;
         ec = '{due: cyc, we: 1'b0, addr: 16'h0, wdata: 16'h0};
         if (cmd_q.size() > 0 && cmd_q[0].due == cyc) begin
            ec = cmd_q.pop_front();
            exp_en = 1'b1;
         end
         check("ram_cmd", {ram_en, ram_we, ram_addr, ram_wdata}, {exp_en, ec.we, ec.addr, ec.wdata});
         exp_rv = 3'b000;
         exp_rd = 16'h0;
         if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
            er = rd_q.pop_front();
            exp_rv = 3'(1 << er.id);
            exp_rd = er.data;
         end
         check("rvalid_rdata", {io_rvalid, f_rvalid, ls_rvalid, rdata}, {exp_rv, exp_rd});
      end
   end

   // One arbitration cycle: drive held requests, check the grant, update the model.
   task automatic step();
      bit [2:0]   rq;
      int         win;
      logic [2:0] g;
`ifdef MEM_ARB_STATS_EN
      check("st_ls_cnt", st_ls_cnt, 64'(m_cnt[LS]));
      check("st_f_cnt", st_f_cnt, 64'(m_cnt[F]));
      check("st_io_cnt", st_io_cnt, 64'(m_cnt[IO]));
      check("st_conf_cnt", st_conf_cnt, 64'(m_conf));
`endif
      rq = {act[IO], act[F], act[LS]};
      ls_req = act[LS]; ls_we = r_we[LS]; ls_addr = r_addr[LS]; ls_wdata = r_wd[LS];
      f_req  = act[F];  f_addr = r_addr[F];
      io_req = act[IO]; io_we = r_we[IO]; io_addr = r_addr[IO]; io_wdata = r_wd[IO];
      #1;
      win = pick(rq, m_starve);
      g = {io_gnt, f_gnt, ls_gnt};
      last_dut_gnt = g;
      for (int i = 0; i < 3; i++) if (g[i]) dut_gnt_cyc[i] = cyc;
      check("gnt", g, (win < 0) ? 64'h0 : 64'(1 << win));
      if (win >= 0) begin
         cmd_q.push_back('{due: cyc + 1, we: r_we[win], addr: r_addr[win],
                           wdata: r_we[win] ? r_wd[win] : 16'h0});
         if (r_we[win]) model_mem[r_addr[win][7:0]] = r_wd[win];
         else rd_q.push_back('{due: cyc + LAT, id: win, data: model_mem[r_addr[win][7:0]]});
         act[win] = 1'b0;
      end
      if (rq[IO] && win != IO) m_starve++;
      else m_starve = 0;
`ifdef MEM_ARB_STATS_EN
      if (stats_clr) begin
         m_cnt = '{0, 0, 0};
         m_conf = 0;
      end else begin
         if (win >= 0) m_cnt[win]++;
         if ($countones(rq) >= 2) m_conf++;
      end
`endif
      @(posedge clk);
      #1;
   endtask

   task automatic arm(input int r, input logic we, input logic [15:0] a, input logic [15:0] d);
      act[r] = 1'b1; r_we[r] = we; r_addr[r] = a; r_wd[r] = d;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      ls_req = 0; f_req = 0; io_req = 0;
      act = '{0, 0, 0};
      cmd_q.delete();
      rd_q.delete();
      m_starve = 0;
      m_cnt = '{0, 0, 0};
      m_conf = 0;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      int c0;
      f_req = 0; ls_req = 0; ls_we = 0; io_req = 0; io_we = 0;
      f_addr = 0; ls_addr = 0; ls_wdata = 0; io_addr = 0; io_wdata = 0;
`ifdef MEM_ARB_STATS_EN
      stats_clr = 0;
`endif
      for (int i = 0; i < 3; i++) begin
         act[i] = 0; r_we[i] = 0; r_addr[i] = 0; r_wd[i] = 0; m_cnt[i] = 0; dut_gnt_cyc[i] = -1;
      end
      for (int i = 0; i < 256; i++) model_mem[i] = init_val(i);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      idle(2);

      // Single fetch read of the preloaded word
      c0 = cyc;
      arm(F, 1'b0, 16'h0010, 16'h0);
      step();
      check("fetch_gnt_cycle", 64'(dut_gnt_cyc[F] - c0), 64'd0);
      idle(3);

      // Three-way contention
      c0 = cyc;
      arm(LS, 1'b0, 16'h0003, 16'h0);
      arm(F, 1'b0, 16'h0004, 16'h0);
      arm(IO, 1'b0, 16'h0005, 16'h0);
      idle(3);
      check("cont_ls_cycle", 64'(dut_gnt_cyc[LS] - c0), 64'd0);
      check("cont_f_cycle", 64'(dut_gnt_cyc[F] - c0), 64'd1);
      check("cont_io_cycle", 64'(dut_gnt_cyc[IO] - c0), 64'd2);
      idle(3);

      // Starvation guard with ls requesting every cycle
      c0 = cyc;
      arm(IO, 1'b0, 16'h0007, 16'h0);
      for (int i = 0; i < 12; i++) begin
         if (!act[LS]) arm(LS, 1'b0, 16'(i), 16'h0);
         step();
         if (i == 8) check("starve_ls_resume", last_dut_gnt, 64'b001);
      end
      check("starve_io_cycle", 64'(dut_gnt_cyc[IO] - c0), 64'd7);
      idle(3);

      // Store then load of the same word
      arm(LS, 1'b1, 16'h0040, 16'h1234);
      step();
      arm(LS, 1'b0, 16'h0040, 16'h0);
      step();
      idle(4);

      // Reset while a fetch read is in flight
      arm(F, 1'b0, 16'h0010, 16'h0);
      step();
      do_reset();
      idle(4);

`ifdef MEM_ARB_STATS_EN
      stats_clr = 1'b1;
      step();
      stats_clr = 1'b0;
      arm(LS, 1'b0, 16'h0001, 16'h0);
      arm(IO, 1'b0, 16'h0002, 16'h0);
      step();
      arm(LS, 1'b0, 16'h0001, 16'h0);
      step();
      step();
      for (int i = 0; i < 3; i++) begin
         arm(LS, 1'b0, 16'h0008, 16'h0);
         step();
      end
      for (int i = 0; i < 2; i++) begin
         arm(IO, 1'b1, 16'h0009, 16'(i));
         step();
      end
      check("stats_ls5", st_ls_cnt, 64'd5);
      check("stats_io3", st_io_cnt, 64'd3);
      check("stats_conf2", st_conf_cnt, 64'd2);
      stats_clr = 1'b1;
      arm(LS, 1'b0, 16'h0008, 16'h0);
      step();
      stats_clr = 1'b0;
      check("stats_cleared", {st_f_cnt, st_ls_cnt, st_io_cnt, st_conf_cnt}, 64'h0);
      idle(3);
`endif

      // Random traffic over a small address window to exercise read-after-write
      for (int n = 0; n < 400; n++) begin
         for (int r = 0; r < 3; r++) begin
            if (!act[r] && $urandom_range(0, 99) < 40)
               arm(r, (r == F) ? 1'b0 : 1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), 16'($urandom));
         end
         step();
      end
      while (act[LS] || act[F] || act[IO]) step();
      idle(5);
      check("drain_rd_q", 64'(rd_q.size()), 64'd0);
      check("drain_cmd_q", 64'(cmd_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
